// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants for the hazard/stall logic and the HI/LO unit.
// Holds the Tuse "never" code, the $0 address, mult/div latencies and the busy-sequencer states.
package hazard_stall_ctrl_pkg;

   localparam logic [1:0] TUSE_NEVER   = 2'd3;
   localparam logic [4:0] REG_ZERO     = 5'd0;
   localparam int         MULT_CYC_DEF = 5;
   localparam int         DIV_CYC_DEF  = 10;
   localparam int         CNT_W_DEF    = 4;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } mdState_t;

   // A producer only hurts if it writes the same non-$0 register later than D needs it.
   // TUSE_NEVER is the largest code, so it can never be exceeded by any Tnew.
   function automatic logic regHazard(
      input logic [4:0] dAddr,
      input logic [1:0] tUse,
      input logic [4:0] wa,
      input logic [1:0] tNew
   );
      return (dAddr != REG_ZERO) && (wa == dAddr) && (tNew > tUse);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// HI/LO busy sequencer: loads the mult/div latency when an op leaves E, counts down to idle.
// md_busy is registered and rises the cycle after the start; starts while busy are ignored.
import hazard_stall_ctrl_pkg::*;

module hazard_stall_ctrl_md_busy_counter #(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic mdStart,
   input  logic mdDiv,
   output logic mdBusy
);

   mdState_t         state;
   mdState_t         stateNext;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   always_comb begin
      cntNext = cnt;
      case (state)
         MD_IDLE: begin
            if (mdStart) begin
               cntNext = mdDiv ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            end
         end
         MD_BUSY: begin
            cntNext = cnt - CNT_W'(1);
         end
         default: cntNext = '0;
      endcase
      // State simply tracks whether the counter is non-zero, so a zero latency never sticks in BUSY.
      stateNext = (cntNext != '0) ? MD_BUSY : MD_IDLE;
   end

   always_comb begin
      mdBusy = (state == MD_BUSY);
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall controller: freezes PC and F/D and bubbles D/E on register hazards or HI/LO busy, same cycle.
// Optional STALL_STATS_EN adds a saturating stall_cycles counter output.
import hazard_stall_ctrl_pkg::*;

module hazard_stall_ctrl #(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  d_rs,
   input  logic [4:0]  d_rt,
   input  logic [1:0]  d_tuse_rs,
   input  logic [1:0]  d_tuse_rt,
   input  logic [4:0]  e_wa,
   input  logic [1:0]  e_tnew,
   input  logic [4:0]  m_wa,
   input  logic [1:0]  m_tnew,
   input  logic        d_is_md,
   input  logic        e_md_start,
   input  logic        e_md_div,
   output logic        pc_en,
   output logic        fd_en,
   output logic        de_clr,
   output logic        md_busy
`ifdef STALL_STATS_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   logic rsStall;
   logic rtStall;
   logic mdStall;
   logic stall;

   hazard_stall_ctrl_md_busy_counter #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC),
      .CNT_W    (CNT_W)
   ) uMdBusy (
      .clk     (clk),
      .reset   (reset),
      .mdStart (e_md_start),
      .mdDiv   (e_md_div),
      .mdBusy  (md_busy)
   );

   always_comb begin
      rsStall = regHazard(d_rs, d_tuse_rs, e_wa, e_tnew) | regHazard(d_rs, d_tuse_rs, m_wa, m_tnew);
      rtStall = regHazard(d_rt, d_tuse_rt, e_wa, e_tnew) | regHazard(d_rt, d_tuse_rt, m_wa, m_tnew);
      // An md op sitting in E has not yet raised md_busy, so it must block the next md op itself.
      mdStall = d_is_md & (md_busy | e_md_start);
      stall   = rsStall | rtStall | mdStall;
   end

   // Reset forces the pipeline free-running regardless of stale hazard inputs.
   always_comb begin
      pc_en  = reset | ~stall;
      fd_en  = reset | ~stall;
      de_clr = ~reset & stall;
   end

`ifdef STALL_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: combinational hazard table plus md/reset sequences.
module tb_hazard_stall_ctrl;
   import hazard_stall_ctrl_pkg::*;

   logic       clk;
   logic       reset;
   logic [4:0] d_rs, d_rt, e_wa, m_wa;
   logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
   logic       d_is_md, e_md_start, e_md_div;
   logic       pc_en, fd_en, de_clr, md_busy;
`ifdef STALL_STATS_EN
   logic [31:0] stall_cycles;
`endif

   int errors = 0;
   int checks = 0;

   hazard_stall_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .e_wa       (e_wa),
      .e_tnew     (e_tnew),
      .m_wa       (m_wa),
      .m_tnew     (m_tnew),
      .d_is_md    (d_is_md),
      .e_md_start (e_md_start),
      .e_md_div   (e_md_div),
      .pc_en      (pc_en),
      .fd_en      (fd_en),
      .de_clr     (de_clr),
      .md_busy    (md_busy)
`ifdef STALL_STATS_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [1:0] tuseRs;
      logic [1:0] tuseRt;
      logic [4:0] eWa;
      logic [1:0] eTnew;
      logic [4:0] mWa;
      logic [1:0] mTnew;
      logic       isMd;
      logic       expStall;
   } vec_t;

   vec_t vecs[11];

   function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] tuseRs, input logic [1:0] tuseRt,
                               input logic [4:0] eWa, input logic [1:0] eTnew,
                               input logic [4:0] mWa, input logic [1:0] mTnew,
                               input logic isMd, input logic expStall);
      vec_t v;
      v.rs = rs; v.rt = rt; v.tuseRs = tuseRs; v.tuseRt = tuseRt;
      v.eWa = eWa; v.eTnew = eTnew; v.mWa = mWa; v.mTnew = mTnew;
      v.isMd = isMd; v.expStall = expStall;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chkStall(input string nm, input logic expStall);
      chk({nm, ".pc_en"},  {31'd0, pc_en},  {31'd0, ~expStall});
      chk({nm, ".fd_en"},  {31'd0, fd_en},  {31'd0, ~expStall});
      chk({nm, ".de_clr"}, {31'd0, de_clr}, {31'd0, expStall});
   endtask

   task automatic quiet();
      d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = TUSE_NEVER; d_tuse_rt = TUSE_NEVER;
      e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd0; m_tnew = 2'd0;
      d_is_md = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
   endtask

   task automatic loadUse();
      d_rs = 5'd5; d_tuse_rs = 2'd1; e_wa = 5'd5; e_tnew = 2'd2;
   endtask

   initial begin
      //               rs  rt tRs tRt eWa eT mWa mT md  stall
      vecs[0]  = mk(5,  0,  1,  3,  5,  2, 0,  0, 0, 1);  // load-use on rs from E
      vecs[1]  = mk(5,  0,  1,  3,  0,  0, 5,  1, 0, 0);  // same producer now in M, ready in time
      vecs[2]  = mk(0,  0,  0,  3,  0,  2, 0,  0, 0, 0);  // $0 immune via E
      vecs[3]  = mk(0,  0,  0,  0,  0,  2, 0,  3, 0, 0);  // $0 immune via M
      vecs[4]  = mk(0,  7,  3,  1,  0,  0, 7,  2, 0, 1);  // rt hazard from M
      vecs[5]  = mk(9,  9,  3,  3,  9,  3, 9,  3, 0, 0);  // never-used operands
      vecs[6]  = mk(4,  0,  2,  3,  4,  2, 0,  0, 0, 0);  // tnew equal to tuse
      vecs[7]  = mk(4,  0,  0,  3,  4,  1, 0,  0, 0, 1);  // tnew one above tuse
      vecs[8]  = mk(4,  6,  0,  0,  5,  2, 3,  2, 0, 0);  // producers write other registers
      vecs[9]  = mk(1,  6,  3,  0,  6,  1, 0,  0, 0, 1);  // rt hazard from E
      vecs[10] = mk(0,  0,  3,  3,  0,  0, 0,  0, 1, 0);  // md op with HI/LO idle

      // Reset: outputs free-running even with a load-use hazard and an md start pending.
      quiet();
      reset = 1'b1;
      loadUse();
      d_is_md = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chkStall("reset_override", 1'b0);
      chk("reset_md_busy", {31'd0, md_busy}, 32'd0);
`ifdef STALL_STATS_EN
      chk("reset_stall_cycles", stall_cycles, 32'd0);
`endif
      reset = 1'b0;
      quiet();

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         d_rs = vecs[i].rs; d_rt = vecs[i].rt;
         d_tuse_rs = vecs[i].tuseRs; d_tuse_rt = vecs[i].tuseRt;
         e_wa = vecs[i].eWa; e_tnew = vecs[i].eTnew;
         m_wa = vecs[i].mWa; m_tnew = vecs[i].mTnew;
         d_is_md = vecs[i].isMd;
         #2;
         chkStall($sformatf("vec%0d", i), vecs[i].expStall);
      end

      // Div: start in cycle 0, md op held in D through cycle 11.
      @(negedge clk);
      quiet();
      e_md_start = 1'b1; e_md_div = 1'b1; d_is_md = 1'b1;
      #2;
      chkStall("div_c0", 1'b1);
      chk("div_c0_busy", {31'd0, md_busy}, 32'd0);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         e_md_start = 1'b0;
         #2;
         chk($sformatf("div_c%0d_busy", c), {31'd0, md_busy}, {31'd0, (c <= 10)});
         chkStall($sformatf("div_c%0d", c), (c <= 10));
      end

      // Mult with a non-md D instruction; a stray div start mid-busy must not reload.
      @(negedge clk);
      quiet();
      e_md_start = 1'b1;
      #2;
      chkStall("mul_c0", 1'b0);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         e_md_start = (c == 2);
         e_md_div   = (c == 2);
         #2;
         chk($sformatf("mul_c%0d_busy", c), {31'd0, md_busy}, {31'd0, (c <= 5)});
         chkStall($sformatf("mul_c%0d", c), 1'b0);
      end

      // Reset mid-div when the count has reached 6 (cycle 5 after the start).
      @(negedge clk);
      quiet();
      e_md_start = 1'b1; e_md_div = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         e_md_start = 1'b0;
      end
      d_is_md = 1'b1;
      reset = 1'b1;
      #2;
      chk("rst_mid_busy_before", {31'd0, md_busy}, 32'd1);
      chkStall("rst_mid_during", 1'b0);
      @(negedge clk);
      #2;
      chk("rst_mid_busy_after", {31'd0, md_busy}, 32'd0);
      chkStall("rst_mid_during2", 1'b0);
      reset = 1'b0;
      #1;
      chkStall("rst_mid_released", 1'b0);

`ifdef STALL_STATS_EN
      // 3 load-use stall cycles plus 10 md stall cycles.
      @(negedge clk);
      quiet();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      loadUse();
      repeat (3) @(negedge clk);
      quiet();
      e_md_start = 1'b1; e_md_div = 1'b1;
      @(negedge clk);
      e_md_start = 1'b0;
      d_is_md = 1'b1;
      repeat (11) @(negedge clk);
      quiet();
      @(negedge clk);
      chk("stats_count", stall_cycles, 32'd13);
      reset = 1'b1;
      loadUse();
      @(negedge clk);
      @(negedge clk);
      chk("stats_reset", stall_cycles, 32'd0);
      reset = 1'b0;
      quiet();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline stall controller for the 5-stage MIPS core.
- Decides each cycle whether the fetch PC and the F/D register freeze and whether the D/E register is cleared (bubble inserted).
- Combines register-hazard detection (Tuse/Tnew) with a multi-cycle mult/div busy sequencer.
- Drives the PC enable input, the F/D enable and the D/E clear.

Parameters:
- MULT_CYC, 5, cycles a mult/multu keeps the HI/LO unit busy after leaving E.
- DIV_CYC, 10, cycles a div/divu keeps the HI/LO unit busy after leaving E.
- CNT_W, 4, busy counter width; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- d_rs  in  5  rs address of instruction in D.
- d_rt  in  5  rt address of instruction in D.
- d_tuse_rs  in  2  cycles until D needs rs (3 = never used).
- d_tuse_rt  in  2  cycles until D needs rt (3 = never used).
- e_wa  in  5  destination register of instruction in E (0 = none).
- e_tnew  in  2  cycles until E result is ready.
- m_wa  in  5  destination register of instruction in M (0 = none).
- m_tnew  in  2  cycles until M result is ready.
- d_is_md  in  1  D holds mult/div/mfhi/mflo/mthi/mtlo.
- e_md_start  in  1  mult/div family instruction is in E this cycle.
- e_md_div  in  1  qualifies e_md_start: 1 = div/divu, 0 = mult/multu.
- pc_en  out  1  PC enable.
- fd_en  out  1  F/D register enable.
- de_clr  out  1  D/E register synchronous clear.
- md_busy  out  1  HI/LO unit busy.

Behaviour:
- Reset and clocking: reset, synchronous, active-high; clock clk.
- rs_stall = (d_rs != 0) & ((e_wa == d_rs & e_tnew > d_tuse_rs) | (m_wa == d_rs & m_tnew > d_tuse_rs)). rt_stall is identical using d_rt / d_tuse_rt.
- md_stall = d_is_md & (md_busy | e_md_start).
- stall = rs_stall | rt_stall | md_stall.
- Outputs are combinational: pc_en = ~stall, fd_en = ~stall, de_clr = stall.
- While reset is high: pc_en = 1, fd_en = 1, de_clr = 0, regardless of the hazard inputs.
- Busy counter cnt[CNT_W-1:0], two states: IDLE (cnt == 0) and BUSY (cnt != 0).
  - IDLE: if e_md_start, the next cycle loads cnt = e_md_div ? DIV_CYC : MULT_CYC and enters BUSY.
  - BUSY: cnt decrements by 1 each cycle; returns to IDLE when it reaches 0.
  - md_busy = (cnt != 0), registered.
- e_md_start while BUSY is ignored: no reload and no error. It cannot occur in legal flow because md_stall blocks issue.
- The counter runs independently of stall; a stalled pipeline does not freeze it.
- Reset mid-operation: cnt cleared to 0 the next edge, md_busy = 0.
- Register $0 never causes a stall, even if e_wa/m_wa equals 0 with a nonzero tnew.
- Latency: a hazard present in cycle t causes stall in cycle t (zero latency). md_busy rises in the cycle after the E-stage start.

Optional Feature:
- Macro STALL_STATS_EN.
- Defined:
  - Extra output stall_cycles [31:0] counts cycles with stall = 1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset; does not count while reset is high.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared constants header: TUSE_NEVER = 2'd3 and register-zero constant.
- MULT_CYC/DIV_CYC defaults also belong in the shared header for reuse by the HI/LO unit.
- One natural sub-module, md_busy_counter: counter plus IDLE/BUSY logic producing md_busy.

Test Plan:
- Load-use: e_wa=5, e_tnew=2, d_rs=5, d_tuse_rs=1 -> stall 1 cycle (pc_en=0, de_clr=1). Next cycle with e_wa=0, m_wa=5, m_tnew=1 -> pc_en=1.
- $0 immunity: d_rs=0, e_wa=0, e_tnew=2, d_tuse_rs=0 -> pc_en=1, de_clr=0.
- Div sequence: e_md_start=1, e_md_div=1 in cycle 0 -> md_busy=1 for cycles 1..10, 0 in cycle 11. d_is_md=1 over cycles 0..11 -> stall cycles 0..10, released cycle 11.
- Mult: same with e_md_div=0 -> md_busy high exactly 5 cycles. Non-md D instruction during busy -> no stall.
- Reset mid-div: assert reset at cnt=6 -> md_busy=0 next cycle; pc_en=1 during reset.
- STALL_STATS_EN build: 3 load-use stalls plus 10 md stalls -> stall_cycles=13. Reset -> 0.
